ps2_keymap: RTL and testbench
=============================

PS2_KEYMAP -- requirements
Module: ps2_keymap

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, is the output FIFO depth in bytes and SHALL be a power of two, at least 4.
REQ-002 clk100  input  1  system clock; one clock, all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_data  input  8  PS/2 Set 2 scancode byte from the PS/2 receiver.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-006 out_data  output  8  translated ASCII or VT100 byte at the FIFO head.
REQ-007 out_valid  output  1  FIFO not empty.
REQ-008 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.
REQ-009 overflow  output  1  one-cycle pulse whenever a byte or sequence is dropped.
REQ-010 caps_led  output  1  current caps-lock state.

Function
REQ-011 Decoder states SHALL be: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (inside a pause sequence).
REQ-012 Transitions: IDLE+E0->EXT; IDLE+F0->BRK; IDLE+E1->SKIP with skip count 7; EXT+F0->EXT_BRK; any other byte in IDLE/EXT->make event, then IDLE; any byte in BRK/EXT_BRK->break event, then IDLE; SKIP decrements per byte and returns to IDLE at 0.
REQ-013 Modifiers: 12/59 set lshift/rshift on make and clear on break; 14 and E0 14 set lctrl/rctrl likewise; 58 make toggles caps; break events otherwise emit nothing.
REQ-014 Make of a mapped key SHALL emit one byte: letters = lowercase ASCII, uppercase if (shift XOR caps); digits/punctuation = US layout, shifted form when shift is held; 29->20, 5A->0D, 66->08, 0D->09, 76->1B.
REQ-015 With either ctrl held, a letter SHALL emit (uppercase ASCII & 0x1F), overriding shift and caps.
REQ-016 E0 75/72/74/6B make SHALL emit the 3 bytes 1B 5B 41/42/43/44 (up/down/right/left), written in consecutive cycles.
REQ-017 Unmapped scancodes, and E0 codes other than those in REQ-013/REQ-016, SHALL emit nothing and return to IDLE.
REQ-018 Latency: with the FIFO empty and the block not busy, out_valid SHALL rise in the 2nd cycle after the rx_valid cycle.
REQ-019 While a 3-byte sequence is being written, one arriving rx_valid byte SHALL be held in a pending register and decoded after the sequence ends; a second arrival while pending is full SHALL be dropped with an overflow pulse.
REQ-020 Emission is all-or-nothing: if free FIFO space is smaller than the byte count, nothing is written and overflow pulses once; decoder and modifier state still update.
REQ-021 FIFO read and write in the same cycle SHALL both occur, including when the FIFO is full (pop frees space first) or empty (no bypass; data appears next cycle).
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-023 out_data SHALL stay stable while out_valid is high and out_ready is low.

Reset
REQ-024 rst SHALL force state IDLE, skip count 0, all modifiers and caps cleared, pending register empty, FIFO empty, out_valid 0, out_data 00, overflow 0, caps_led 0.
REQ-025 rst asserted mid-sequence or mid-prefix SHALL abandon it, with no partial bytes remaining after reset.

Structure
REQ-026 Package ps2_pkg SHALL hold the scancode constants (E0, E1, F0, modifier codes, arrow codes), ASCII constants, and the decoder state enumeration.
REQ-027 The FIFO SHALL be a sub-module byte_fifo (parameter DEPTH, ports push/din/pop/dout/full/empty/count); the scancode-to-ASCII tables stay in ps2_keymap.

Verification
REQ-028 rx 1C -> out 61; rx 12,1C -> out 41; rx F0,12 then 1C -> out 61.
REQ-029 rx 58,F0,58,1C -> caps_led=1, out 41; then rx 12,1C -> out 61.
REQ-030 rx 14,21 (ctrl+c) -> out 03; rx E0,75 -> out 1B,5B,41 in consecutive cycles.
REQ-031 out_ready=0, fill FIFO with 7 bytes, then rx E0,72 -> overflow pulses, count stays 7; next rx 1C -> 8th byte 61 accepted.
REQ-032 rx E1,14,77,E1,F0,14,F0,77 then 1C -> only 61 is output; rst asserted after E0 -> following 75 emits nothing.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 Set 2 scancode constants, ASCII/VT100 constants
//               and the decoder state enumeration for ps2_keymap.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Prefix and framing scancodes
  localparam logic [7:0] c_SC_E0     = 8'hE0;
  localparam logic [7:0] c_SC_E1     = 8'hE1;
  localparam logic [7:0] c_SC_F0     = 8'hF0;

  // Modifier scancodes (ctrl is 14 plain for left, E0 14 for right)
  localparam logic [7:0] c_SC_LSHIFT = 8'h12;
  localparam logic [7:0] c_SC_RSHIFT = 8'h59;
  localparam logic [7:0] c_SC_CTRL   = 8'h14;
  localparam logic [7:0] c_SC_CAPS   = 8'h58;

  // Extended (E0-prefixed) arrow scancodes
  localparam logic [7:0] c_SC_UP     = 8'h75;
  localparam logic [7:0] c_SC_DOWN   = 8'h72;
  localparam logic [7:0] c_SC_RIGHT  = 8'h74;
  localparam logic [7:0] c_SC_LEFT   = 8'h6B;

  // ASCII / VT100 output bytes
  localparam logic [7:0] c_ASCII_ESC  = 8'h1B;
  localparam logic [7:0] c_ASCII_LBR  = 8'h5B;
  localparam logic [7:0] c_VT_UP      = 8'h41;
  localparam logic [7:0] c_VT_DOWN    = 8'h42;
  localparam logic [7:0] c_VT_RIGHT   = 8'h43;
  localparam logic [7:0] c_VT_LEFT    = 8'h44;
  localparam logic [7:0] c_UPPER_MASK = 8'hDF;  // clears the lowercase bit
  localparam logic [7:0] c_CTRL_MASK  = 8'h1F;

  // Number of bytes following E1 in the pause sequence
  localparam logic [2:0] c_PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous byte FIFO, power-of-two depth, extra pointer bit
//               distinguishes full from empty. Pop frees space before push.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_PTR_ONE = 1;

  logic [7:0]    r_mem [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic          w_do_pop;
  logic          w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  // Head is forced to zero when empty so the visible byte is defined after reset
  assign dout      = empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];

  // Pointer update; both may move in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_keymap.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keymap
// Description : PS/2 Set 2 scancode to ASCII / VT100 translator with modifier
//               tracking, one-byte pending register and an output byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keymap import ps2_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       caps_led
);

  localparam int                c_AW      = $clog2(FIFO_DEPTH);
  localparam logic [c_AW+1:0]   c_DEPTH_V = FIFO_DEPTH[c_AW+1:0];

  // Lowercase letter for a scancode, zero when not a letter
  function automatic logic [7:0] letter_lc(input logic [7:0] sc);
    case (sc)
      8'h1C: return "a";  8'h32: return "b";  8'h21: return "c";  8'h23: return "d";
      8'h24: return "e";  8'h2B: return "f";  8'h34: return "g";  8'h33: return "h";
      8'h43: return "i";  8'h3B: return "j";  8'h42: return "k";  8'h4B: return "l";
      8'h3A: return "m";  8'h31: return "n";  8'h44: return "o";  8'h4D: return "p";
      8'h15: return "q";  8'h2D: return "r";  8'h1B: return "s";  8'h2C: return "t";
      8'h3C: return "u";  8'h2A: return "v";  8'h1D: return "w";  8'h22: return "x";
      8'h35: return "y";  8'h1A: return "z";
      default: return 8'h00;
    endcase
  endfunction

  // {unshifted, shifted} for digits, punctuation and control keys, zero if unmapped
  function automatic logic [15:0] sym_map(input logic [7:0] sc);
    case (sc)
      8'h16: return "1!";  8'h1E: return "2@";  8'h26: return "3#";  8'h25: return "4$";
      8'h2E: return "5%";  8'h36: return "6^";  8'h3D: return "7&";  8'h3E: return "8*";
      8'h46: return "9(";  8'h45: return "0)";  8'h0E: return "`~";  8'h4E: return "-_";
      8'h55: return "=+";  8'h54: return "[{";  8'h5B: return "]}";  8'h5D: return 16'h5C7C;
      8'h4C: return ";:";  8'h52: return 16'h2722; 8'h41: return ",<";  8'h49: return ".>";
      8'h4A: return "/?";
      8'h29: return 16'h2020;  8'h5A: return 16'h0D0D;  8'h66: return 16'h0808;
      8'h0D: return 16'h0909;  8'h76: return 16'h1B1B;
      default: return 16'h0000;
    endcase
  endfunction

  dec_state_t    r_state;
  logic [2:0]    r_skip;
  logic          r_lshift, r_rshift, r_lctrl, r_rctrl, r_caps;
  logic          r_in_vld;
  logic [7:0]    r_in_data;
  logic [1:0]    r_seq_cnt;
  logic [7:0]    r_seq_last;
  logic          r_overflow;

  logic          w_busy, w_take, w_rx_drop;
  logic          w_is_make, w_is_break, w_ext;
  logic [7:0]    w_letter;
  logic [15:0]   w_sym;
  logic          w_shift, w_ctrl;
  logic [1:0]    w_emit_cnt;
  logic [7:0]    w_emit_byte, w_emit_last;
  logic          w_fits, w_emit_ok, w_emit_drop;
  logic          w_push, w_pop, w_full, w_empty;
  logic [7:0]    w_din;
  logic [c_AW:0] w_count;
  logic [c_AW+1:0] w_space;

  assign w_busy    = (r_seq_cnt != 2'd0);
  assign w_take    = r_in_vld && !w_busy;
  assign w_rx_drop = rx_valid && r_in_vld && !w_take;
  assign w_letter  = letter_lc(r_in_data);
  assign w_sym     = sym_map(r_in_data);
  assign w_shift   = r_lshift | r_rshift;
  assign w_ctrl    = r_lctrl | r_rctrl;

  // Classify the byte being decoded as a make or break event
  always_comb begin
    w_is_make  = 1'b0;
    w_is_break = 1'b0;
    w_ext      = 1'b0;
    if (w_take) begin
      case (r_state)
        ST_IDLE:    w_is_make = (r_in_data != c_SC_E0) && (r_in_data != c_SC_F0) &&
                                (r_in_data != c_SC_E1);
        ST_EXT:     begin w_is_make = (r_in_data != c_SC_F0); w_ext = 1'b1; end
        ST_BRK:     w_is_break = 1'b1;
        ST_EXT_BRK: begin w_is_break = 1'b1; w_ext = 1'b1; end
        default:    ;
      endcase
    end
  end

  // Select the bytes a make event produces
  always_comb begin
    w_emit_cnt  = 2'd0;
    w_emit_byte = 8'h00;
    w_emit_last = 8'h00;
    if (w_is_make) begin
      if (w_ext) begin
        w_emit_byte = c_ASCII_ESC;
        case (r_in_data)
          c_SC_UP:    begin w_emit_cnt = 2'd3; w_emit_last = c_VT_UP;    end
          c_SC_DOWN:  begin w_emit_cnt = 2'd3; w_emit_last = c_VT_DOWN;  end
          c_SC_RIGHT: begin w_emit_cnt = 2'd3; w_emit_last = c_VT_RIGHT; end
          c_SC_LEFT:  begin w_emit_cnt = 2'd3; w_emit_last = c_VT_LEFT;  end
          default:    w_emit_byte = 8'h00;
        endcase
      end else if (w_letter != 8'h00) begin
        w_emit_cnt = 2'd1;
        if (w_ctrl)                w_emit_byte = w_letter & c_UPPER_MASK & c_CTRL_MASK;
        else if (w_shift ^ r_caps) w_emit_byte = w_letter & c_UPPER_MASK;
        else                       w_emit_byte = w_letter;
      end else if (w_sym != 16'h0000) begin
        w_emit_cnt  = 2'd1;
        w_emit_byte = w_shift ? w_sym[7:0] : w_sym[15:8];
      end
    end
  end

  // Space available this cycle counts a simultaneous pop as already freed
  assign w_pop       = out_ready && !w_empty;
  assign w_space     = (w_full ? '0 : c_DEPTH_V - {1'b0, w_count}) + {{(c_AW+1){1'b0}}, w_pop};
  assign w_fits      = ({{c_AW{1'b0}}, w_emit_cnt} <= w_space);
  assign w_emit_ok   = (w_emit_cnt != 2'd0) && w_fits;
  assign w_emit_drop = (w_emit_cnt != 2'd0) && !w_fits;
  assign w_push      = w_busy || w_emit_ok;
  assign w_din       = w_busy ? ((r_seq_cnt == 2'd2) ? c_ASCII_LBR : r_seq_last) : w_emit_byte;

  // Input / pending register: refills when empty or when its byte is consumed
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_in_vld  <= 1'b0;
      r_in_data <= 8'h00;
    end else if (rx_valid && (!r_in_vld || w_take)) begin
      r_in_vld  <= 1'b1;
      r_in_data <= rx_data;
    end else if (w_take) begin
      r_in_vld  <= 1'b0;
    end
  end

  // Tail of a 3-byte escape sequence: remaining count and final byte
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_seq_cnt  <= 2'd0;
      r_seq_last <= 8'h00;
    end else if (w_busy) begin
      r_seq_cnt  <= r_seq_cnt - 2'd1;
    end else if (w_emit_ok && (w_emit_cnt == 2'd3)) begin
      r_seq_cnt  <= 2'd2;
      r_seq_last <= w_emit_last;
    end
  end

  // Prefix decoder and modifier state; modifiers update even when output drops
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_skip   <= 3'd0;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_lctrl  <= 1'b0;
      r_rctrl  <= 1'b0;
      r_caps   <= 1'b0;
    end else if (w_take) begin
      case (r_state)
        ST_IDLE: begin
          if (r_in_data == c_SC_E0)      r_state <= ST_EXT;
          else if (r_in_data == c_SC_F0) r_state <= ST_BRK;
          else if (r_in_data == c_SC_E1) begin
            r_state <= ST_SKIP;
            r_skip  <= c_PAUSE_SKIP;
          end
        end
        ST_EXT:  r_state <= (r_in_data == c_SC_F0) ? ST_EXT_BRK : ST_IDLE;
        ST_SKIP: begin
          r_skip <= (r_skip == 3'd0) ? 3'd0 : r_skip - 3'd1;
          if (r_skip <= 3'd1) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_is_make) begin
        if (w_ext) begin
          if (r_in_data == c_SC_CTRL) r_rctrl <= 1'b1;
        end else begin
          case (r_in_data)
            c_SC_LSHIFT: r_lshift <= 1'b1;
            c_SC_RSHIFT: r_rshift <= 1'b1;
            c_SC_CTRL:   r_lctrl  <= 1'b1;
            c_SC_CAPS:   r_caps   <= ~r_caps;
            default:     ;
          endcase
        end
      end
      if (w_is_break) begin
        if (w_ext) begin
          if (r_in_data == c_SC_CTRL) r_rctrl <= 1'b0;
        end else begin
          case (r_in_data)
            c_SC_LSHIFT: r_lshift <= 1'b0;
            c_SC_RSHIFT: r_rshift <= 1'b0;
            c_SC_CTRL:   r_lctrl  <= 1'b0;
            default:     ;
          endcase
        end
      end
    end
  end

  // Single pulse for any dropped input byte or dropped emission
  always_ff @(posedge clk100) begin
    if (rst) r_overflow <= 1'b0;
    else     r_overflow <= w_rx_drop | w_emit_drop;
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk100),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (out_ready),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign out_valid = !w_empty;
  assign overflow  = r_overflow;
  assign caps_led  = r_caps;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keymap.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_keymap
// Description : Self-checking bench for ps2_keymap: directed scenarios plus a
//               randomized scancode stream against a keyboard-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keymap;

  logic       clk100 = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       caps_led;

  always #5 clk100 = ~clk100;

  ps2_keymap #(.FIFO_DEPTH(8)) dut (
    .clk100    (clk100),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .caps_led  (caps_led)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] got_q[$];
  int         got_idx  = 0;
  int         ovf_cnt  = 0;
  bit         rnd_ready = 1'b0;

  // Keyboard-level reference model
  logic [7:0] m_lower[256];
  logic [7:0] m_norm[256];
  logic [7:0] m_shift[256];
  logic [7:0] pool[$];
  logic [7:0] exp_q[$];
  bit         m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_caps;
  int         m_skip;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Record accepted bytes and overflow pulses mid-cycle
  always @(negedge clk100) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (overflow) ovf_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk100);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got_idx = got_q.size();
  endtask

  // Drain and compare n bytes, first byte in the most significant position
  task automatic expect_out(input string tag, input int n, input logic [63:0] bytes);
    out_ready = 1'b1;
    repeat (14) tick();
    check({tag, " count"}, got_q.size() - got_idx, n);
    for (int i = 0; i < n; i++)
      check(tag, (got_idx + i < got_q.size()) ? {24'h0, got_q[got_idx + i]} : 32'hFFFF_FFFF,
            {24'h0, bytes[8*(n-1-i) +: 8]});
    got_idx = got_q.size();
  endtask

  task automatic model_init();
    string lt = "abcdefghijklmnopqrstuvwxyz";
    logic [7:0] lc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                           8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] sn[21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                           8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                           8'h2C, 8'h2E, 8'h2F};
    logic [7:0] ss[21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28,
                           8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                           8'h3C, 8'h3E, 8'h3F};
    logic [7:0] sc[21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                           8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                           8'h41, 8'h49, 8'h4A};
    logic [7:0] kc[5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] ka[5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
    logic [7:0] extra[10] = '{8'h12, 8'h59, 8'h14, 8'h58, 8'h75, 8'h72, 8'h74, 8'h6B,
                              8'h05, 8'h7E};
    for (int i = 0; i < 256; i++) begin m_lower[i] = 0; m_norm[i] = 0; m_shift[i] = 0; end
    for (int i = 0; i < 26; i++) begin m_lower[lc[i]] = lt[i]; pool.push_back(lc[i]); end
    for (int i = 0; i < 21; i++) begin
      m_norm[sc[i]] = sn[i]; m_shift[sc[i]] = ss[i]; pool.push_back(sc[i]);
    end
    for (int i = 0; i < 5; i++) begin m_norm[kc[i]] = ka[i]; m_shift[kc[i]] = ka[i]; pool.push_back(kc[i]); end
    for (int i = 0; i < 10; i++) begin pool.push_back(extra[i]); pool.push_back(extra[i]); end
    {m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_caps} = '0;
    m_skip = 0;
  endtask

  task automatic model_key(input bit ext, input bit make, input logic [7:0] b);
    if (!make) begin
      if (ext) begin if (b == 8'h14) m_rc = 0; end
      else if (b == 8'h12) m_ls = 0;
      else if (b == 8'h59) m_rs = 0;
      else if (b == 8'h14) m_lc = 0;
    end else if (ext) begin
      if (b == 8'h14) m_rc = 1;
      else if (b == 8'h75 || b == 8'h72 || b == 8'h74 || b == 8'h6B) begin
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B);
        exp_q.push_back(b == 8'h75 ? 8'h41 : b == 8'h72 ? 8'h42 : b == 8'h74 ? 8'h43 : 8'h44);
      end
    end else if (b == 8'h12) m_ls = 1;
    else if (b == 8'h59) m_rs = 1;
    else if (b == 8'h14) m_lc = 1;
    else if (b == 8'h58) m_caps = !m_caps;
    else if (m_lower[b] != 0) begin
      if (m_lc || m_rc)                 exp_q.push_back(m_lower[b] - 8'h60);
      else if ((m_ls || m_rs) ^ m_caps) exp_q.push_back(m_lower[b] - 8'h20);
      else                              exp_q.push_back(m_lower[b]);
    end else if (m_norm[b] != 0) exp_q.push_back((m_ls || m_rs) ? m_shift[b] : m_norm[b]);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (m_brk) begin model_key(m_ext, 0, b); m_ext = 0; m_brk = 0; end
    else if (b == 8'hF0) m_brk = 1;
    else if (m_ext) begin model_key(1, 1, b); m_ext = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hE1) m_skip = 7;
    else model_key(0, 1, b);
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 99);
    if (r < 10) return 8'hE0;
    if (r < 24) return 8'hF0;
    if (r < 26) return 8'hE1;
    if (r < 31) return 8'($urandom);
    return pool[$urandom_range(0, pool.size() - 1)];
  endfunction

  initial begin
    int base;
    int w;
    logic [7:0] b;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; out_ready = 1'b0;
    model_init();
    repeat (3) tick();
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 8'h00);
    check("rst overflow", overflow, 0);
    check("rst caps_led", caps_led, 0);
    rst = 1'b0;
    tick();

    // Latency and hold under backpressure
    send(8'h1C);
    check("latency cyc1", out_valid, 0);
    tick();
    check("latency cyc2", out_valid, 1);
    check("latency data", out_data, 8'h61);
    tick();
    check("hold data", out_data, 8'h61);
    expect_out("a", 1, 64'h61);
    send(8'h12); send(8'h1C);
    expect_out("shift a", 1, 64'h41);
    send(8'hF0); send(8'h12); send(8'h1C);
    expect_out("shift released", 1, 64'h61);

    do_reset();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    tick();
    check("caps_led", caps_led, 1);
    expect_out("caps a", 1, 64'h41);
    send(8'h12); send(8'h1C);
    expect_out("caps shift a", 1, 64'h61);

    do_reset();
    send(8'h14); send(8'h21);
    expect_out("ctrl c", 1, 64'h03);

    // Arrow bytes in consecutive cycles
    do_reset();
    out_ready = 1'b1;
    send(8'hE0); send(8'h75);
    tick();
    check("up b0 valid", out_valid, 1);
    check("up b0", out_data, 8'h1B);
    tick();
    check("up b1", out_data, 8'h5B);
    tick();
    check("up b2", out_data, 8'h41);
    repeat (4) tick();
    got_idx = got_q.size();

    // All-or-nothing emission near full
    do_reset();
    out_ready = 1'b0;
    base = ovf_cnt;
    repeat (7) send(8'h1C);
    repeat (3) tick();
    send(8'hE0); send(8'h72);
    repeat (3) tick();
    check("seq drop overflow", ovf_cnt - base, 1);
    send(8'h1C);
    repeat (3) tick();
    check("8th byte no overflow", ovf_cnt - base, 1);
    expect_out("fill", 8, 64'h6161616161616161);

    // Pending register holds one byte during a sequence, second is dropped
    do_reset();
    out_ready = 1'b1;
    base = ovf_cnt;
    send(8'hE0); send(8'h75); send(8'h1C); send(8'h32);
    expect_out("pending", 4, 64'h1B5B4161);
    check("pending overflow", ovf_cnt - base, 1);

    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h1C);
    expect_out("pause", 1, 64'h61);

    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h75);
    expect_out("rst after E0", 0, 64'h0);

    do_reset();
    out_ready = 1'b0;
    send(8'hE0); send(8'h75);
    tick();
    do_reset();
    check("rst mid-seq valid", out_valid, 0);
    repeat (4) tick();
    check("rst mid-seq after", out_valid, 0);
    check("rst mid-seq data", out_data, 8'h00);

    // Randomized stream against the model
    do_reset();
    base = ovf_cnt;
    exp_q.delete();
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      b = pick();
      model_byte(b);
      send(b);
      tick();
      w = 0;
      while (out_valid && w < 200) begin tick(); w++; end
      if (w >= 200) check("drain timeout", out_valid, 0);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    check("rand count", got_q.size() - got_idx, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("rand byte", (got_idx + i < got_q.size()) ? {24'h0, got_q[got_idx + i]} : 32'hFFFF_FFFF,
            {24'h0, exp_q[i]});
    check("rand overflow", ovf_cnt - base, 0);
    check("rand caps_led", caps_led, m_caps);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
